// File: rtl/aes_word_stream_bridge_if.sv
// Bundle of every non-clock signal of the AES word stream bridge.
// The slave modport is the bridge's view. The master modport is the view of
// everything around it: word source, word sink, key loader and the AES core.
interface aes_word_stream_bridge_if;

  // key loading
  logic [127:0] key_in;
  logic         key_wr;
  logic         key_ready;

  // plaintext word stream
  logic [31:0]  in_word;
  logic         in_valid;
  logic         in_ready;

  // ciphertext word stream
  logic [31:0]  out_word;
  logic         out_valid;
  logic         out_ready;

  // error reporting
  logic         err_timeout;
  logic         err_clr;

  // AES_top side
  logic         AES_en;
  logic [127:0] AES_data_in;
  logic [127:0] AES_key_in;
  logic [127:0] AES_data_out;
  logic         AES_data_out_valid;

  modport slave (
    input  key_in,
    input  key_wr,
    input  in_word,
    input  in_valid,
    input  out_ready,
    input  err_clr,
    input  AES_data_out,
    input  AES_data_out_valid,
    output key_ready,
    output in_ready,
    output out_word,
    output out_valid,
    output err_timeout,
    output AES_en,
    output AES_data_in,
    output AES_key_in
  );

  modport master (
    output key_in,
    output key_wr,
    output in_word,
    output in_valid,
    output out_ready,
    output err_clr,
    output AES_data_out,
    output AES_data_out_valid,
    input  key_ready,
    input  in_ready,
    input  out_word,
    input  out_valid,
    input  err_timeout,
    input  AES_en,
    input  AES_data_in,
    input  AES_key_in
  );

endinterface

// File: rtl/aes_word_stream_bridge.sv
// Word-level front/back end for AES_top.
// Collects four 32-bit plaintext words into a 128-bit block and holds AES_en
// high until the core reports a result or the watchdog expires. It then
// streams the 128-bit ciphertext back out as four words, most significant
// word first. The input buffer and the output buffer are separate, so the
// next block can be collected while the current one is encrypted or drained.
module aes_word_stream_bridge #(
  parameter int TIMEOUT_CYCLES = 128
) (
  input  logic                     AES_clk,
  input  logic                     AES_rst_n,
  aes_word_stream_bridge_if.slave  bus
);

  // Watchdog width. TIMEOUT_CYCLES >= 2 keeps this at least one bit wide.
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic [2:0]    in_cnt_q;
  logic [127:0]  in_buf_q;
  logic [2:0]    out_cnt_q;
  logic [127:0]  out_buf_q;
  logic [127:0]  key_q;
  logic [127:0]  data_in_q;
  logic [TW-1:0] to_cnt_q;
  logic          err_q;

  logic          in_full;
  logic          in_accept;
  logic          out_pending;
  logic          out_accept;
  logic          start_run;
  logic          run_done;
  logic          run_abort;
  logic [31:0]   out_word_sel;

  // Handshake decodes. in_ready depends only on the counter, so there is no
  // path from in_valid to in_ready.
  assign in_full     = (in_cnt_q == 3'd4);
  assign in_accept   = bus.in_valid && !in_full;
  assign out_pending = (out_cnt_q != 3'd0);
  assign out_accept  = out_pending && bus.out_ready;

  // Next-state decode. A block starts only from IDLE, which guarantees that
  // AES_en is low for at least one cycle between blocks. A result from the
  // core wins over a watchdog expiry in the same cycle.
  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    run_done  = 1'b0;
    run_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_full && !out_pending) begin
          start_run = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (bus.AES_data_out_valid) begin
          run_done = 1'b1;
          state_d  = IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          run_abort = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. AES_en is decoded from it, so reset drops AES_en at once.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Input collection. Slot 0 is the most significant word. The buffer is
  // handed to the core when a run starts, so collection of the next block
  // can continue during RUN.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      in_cnt_q <= 3'd0;
      in_buf_q <= '0;
    end else if (start_run) begin
      in_cnt_q <= 3'd0;
    end else if (in_accept) begin
      case (in_cnt_q[1:0])
        2'd0:    in_buf_q[127:96] <= bus.in_word;
        2'd1:    in_buf_q[95:64]  <= bus.in_word;
        2'd2:    in_buf_q[63:32]  <= bus.in_word;
        default: in_buf_q[31:0]   <= bus.in_word;
      endcase
      in_cnt_q <= in_cnt_q + 3'd1;
    end
  end

  // AES_data_in snapshot. It stays stable for the whole run even though
  // the input buffer keeps filling.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      data_in_q <= '0;
    end else if (start_run) begin
      data_in_q <= in_buf_q;
    end
  end

  // Key register. It is locked while a block is in the core, so the key
  // seen by AES_top cannot change in the middle of an encryption.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      key_q <= '0;
    end else if (bus.key_wr && (state_q != RUN)) begin
      key_q <= bus.key_in;
    end
  end

  // Watchdog. It counts the cycles spent in RUN and is cleared when a
  // block starts.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      to_cnt_q <= '0;
    end else if (start_run) begin
      to_cnt_q <= '0;
    end else if (state_q == RUN) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  // Output buffer. It is loaded from the core and drained one word per
  // accepted handshake. A new run cannot start until it is empty, so a load
  // and a drain never happen in the same cycle.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      out_buf_q <= '0;
      out_cnt_q <= 3'd0;
    end else if (run_done) begin
      out_buf_q <= bus.AES_data_out;
      out_cnt_q <= 3'd4;
    end else if (out_accept) begin
      out_cnt_q <= out_cnt_q - 3'd1;
    end
  end

  // Sticky timeout flag. A clear request wins over a timeout in the same
  // cycle.
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      err_q <= 1'b0;
    end else if (bus.err_clr) begin
      err_q <= 1'b0;
    end else if (run_abort) begin
      err_q <= 1'b1;
    end
  end

  // Output word select. A count of 4 means the most significant word goes
  // next. The select holds while the sink stalls.
  always_comb begin
    out_word_sel = 32'd0;
    case (out_cnt_q)
      3'd4:    out_word_sel = out_buf_q[127:96];
      3'd3:    out_word_sel = out_buf_q[95:64];
      3'd2:    out_word_sel = out_buf_q[63:32];
      3'd1:    out_word_sel = out_buf_q[31:0];
      default: out_word_sel = 32'd0;
    endcase
  end

  assign bus.in_ready    = !in_full;
  assign bus.key_ready   = (state_q != RUN);
  assign bus.out_valid   = out_pending;
  assign bus.out_word    = out_word_sel;
  assign bus.err_timeout = err_q;
  assign bus.AES_en      = (state_q == RUN);
  assign bus.AES_data_in = data_in_q;
  assign bus.AES_key_in  = key_q;

endmodule

// File: tb/tb_aes_word_stream_bridge.sv
// Self-checking bench for aes_word_stream_bridge.
// A stub AES core answers after a configurable latency and can be muted to
// force a timeout. The reference model is a set of queues: words are grouped
// into blocks, and each block becomes four expected ciphertext words.
module tb_aes_word_stream_bridge;

  localparam logic [127:0] KEY_F = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_F  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_F  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk;
  logic rst_n;

  aes_word_stream_bridge_if bus();

  aes_word_stream_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .AES_clk   (clk),
    .AES_rst_n (rst_n),
    .bus       (bus)
  );

  int total = 0;
  int bad   = 0;

  // stub and model state
  int           stub_cnt  = 0;
  int           cur_lat   = 1;
  int           lat_cfg   = 4;
  bit           stub_mute = 0;
  bit           stray     = 0;
  logic [127:0] run_blk;
  logic [127:0] run_key;
  logic [127:0] model_key = '0;
  logic [31:0]  in_words[$];
  logic [127:0] blk_q[$];
  logic [31:0]  exp_out[$];
  int           rx_count = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Stand-in for AES_top. The FIPS-197 vector gives its real ciphertext;
  // any other block gets an easy-to-compute scramble.
  function automatic logic [127:0] stub_cipher(input logic [127:0] d, input logic [127:0] k);
    if (d == PT_F && k == KEY_F) return CT_F;
    return {d[95:0], d[127:96]} ^ k ^ 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: four accepted words make a block.
  task automatic model_accept(input logic [31:0] w);
    logic [127:0] blk;
    logic [127:0] c;
    in_words.push_back(w);
    if (in_words.size() == 4) begin
      blk = {in_words[0], in_words[1], in_words[2], in_words[3]};
      in_words.delete();
      blk_q.push_back(blk);
      if (!stub_mute) begin
        c = stub_cipher(blk, model_key);
        exp_out.push_back(c[127:96]);
        exp_out.push_back(c[95:64]);
        exp_out.push_back(c[63:32]);
        exp_out.push_back(c[31:0]);
      end
    end
  endtask

  // Stub core, driven away from the active edge. It also checks the block
  // presented at each run start and that the block stays stable.
  always @(negedge clk) begin
    if (!rst_n) begin
      stub_cnt = 0;
      bus.AES_data_out_valid = 1'b0;
    end else if (bus.AES_en) begin
      if (stub_cnt == 0) begin
        if (blk_q.size() == 0) begin
          check_output("run_without_block", 128'(blk_q.size()), 128'd1);
          run_blk = bus.AES_data_in;
        end else begin
          run_blk = blk_q.pop_front();
          check_output("run_start_data", bus.AES_data_in, run_blk);
        end
        run_key = model_key;
        check_output("run_start_key", bus.AES_key_in, run_key);
        cur_lat = (lat_cfg == 0) ? int'($urandom_range(1, 12)) : lat_cfg;
      end else begin
        check_output("data_in_stable", bus.AES_data_in, run_blk);
        check_output("key_in_stable", bus.AES_key_in, run_key);
      end
      stub_cnt++;
      if (!stub_mute && stub_cnt == cur_lat) begin
        bus.AES_data_out_valid = 1'b1;
        bus.AES_data_out = stub_cipher(bus.AES_data_in, bus.AES_key_in);
      end else begin
        bus.AES_data_out_valid = 1'b0;
        bus.AES_data_out = {4{$urandom()}};
      end
    end else begin
      stub_cnt = 0;
      bus.AES_data_out_valid = stray;
      bus.AES_data_out = {4{$urandom()}};
    end
  end

  // Output monitor: compares every accepted word with the model's next word.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_out.size() == 0) begin
        check_output("out_extra_word", 128'(exp_out.size()), 128'd1);
      end else begin
        check_output("out_word", {96'd0, bus.out_word}, {96'd0, exp_out.pop_front()});
      end
      rx_count++;
    end
  end

  task automatic push_word(input logic [31:0] w);
    int guard = 0;
    bit rdy;
    bit done = 0;
    bus.in_word  = w;
    bus.in_valid = 1'b1;
    while (!done && guard < 300) begin
      rdy = bus.in_ready;
      tick();
      guard++;
      if (rdy) done = 1;
    end
    bus.in_valid = 1'b0;
    check_output("push_accepted", {127'd0, done}, 128'd1);
    if (done) model_accept(w);
  endtask

  task automatic push_block(input logic [127:0] b);
    push_word(b[127:96]);
    push_word(b[95:64]);
    push_word(b[63:32]);
    push_word(b[31:0]);
  endtask

  task automatic write_key_idle(input logic [127:0] k);
    check_output("key_ready_idle", {127'd0, bus.key_ready}, 128'd1);
    bus.key_in = k;
    bus.key_wr = 1'b1;
    tick();
    bus.key_wr = 1'b0;
    model_key  = k;
    check_output("key_idle_visible", bus.AES_key_in, k);
  endtask

  task automatic wait_quiet();
    int guard = 0;
    bus.out_ready = 1'b1;
    while ((exp_out.size() != 0 || bus.AES_en || bus.out_valid) && guard < 2000) begin
      tick();
      guard++;
    end
    check_output("quiet_reached", {127'd0, guard < 2000}, 128'd1);
  endtask

  task automatic wait_en_rise();
    int guard = 0;
    while (!bus.AES_en && guard < 200) begin
      tick();
      guard++;
    end
    check_output("en_rise_seen", {127'd0, bus.AES_en}, 128'd1);
  endtask

  task automatic measure_timeout_run(output int n);
    n = 0;
    wait_en_rise();
    while (bus.AES_en && n < 100) begin
      n++;
      tick();
    end
  endtask

  initial begin : main
    int n;
    int target;
    bus.key_in = '0;
    bus.key_wr = 1'b0;
    bus.in_word = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.err_clr = 1'b0;
    bus.AES_data_out = '0;
    bus.AES_data_out_valid = 1'b0;
    rst_n = 1'b0;

    // reset values
    #12;
    check_output("rst_key_ready", {127'd0, bus.key_ready}, 128'd1);
    check_output("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
    check_output("rst_aes_en", {127'd0, bus.AES_en}, 128'd0);
    check_output("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check_output("rst_err", {127'd0, bus.err_timeout}, 128'd0);
    check_output("rst_data_in", bus.AES_data_in, 128'd0);
    check_output("rst_key_in", bus.AES_key_in, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // FIPS-197 block with gaps between the input words
    write_key_idle(KEY_F);
    push_word(PT_F[127:96]); tick();
    push_word(PT_F[95:64]);  tick();
    push_word(PT_F[63:32]);  tick();
    push_word(PT_F[31:0]);
    check_output("in_ready_full", {127'd0, bus.in_ready}, 128'd0);
    check_output("en_low_after_4th", {127'd0, bus.AES_en}, 128'd0);
    tick();
    check_output("en_high_t_plus_1", {127'd0, bus.AES_en}, 128'd1);
    check_output("fips_data_in", bus.AES_data_in, PT_F);
    check_output("key_ready_run", {127'd0, bus.key_ready}, 128'd0);
    bus.key_in = {4{$urandom()}};
    bus.key_wr = 1'b1;
    tick();
    bus.key_wr = 1'b0;
    check_output("key_wr_in_run_ignored", bus.AES_key_in, KEY_F);
    wait_quiet();
    check_output("en_low_after_fips", {127'd0, bus.AES_en}, 128'd0);

    // a stray valid outside RUN must not produce output
    stray = 1;
    repeat (3) tick();
    check_output("stray_valid_ignored", {127'd0, bus.out_valid}, 128'd0);
    stray = 0;
    tick();

    // backpressure with a second block collected meanwhile
    bus.out_ready = 1'b0;
    push_block(PT_F);
    n = 0;
    while (!bus.out_valid && n < 100) begin tick(); n++; end
    check_output("bp_out_valid", {127'd0, bus.out_valid}, 128'd1);
    check_output("bp_first_word", {96'd0, bus.out_word}, {96'd0, CT_F[127:96]});
    push_block(PT_F);
    check_output("bp_in_held", {127'd0, bus.in_ready}, 128'd0);
    for (int i = 0; i < 16; i++) begin
      check_output("bp_word_stable", {96'd0, bus.out_word}, {96'd0, CT_F[127:96]});
      check_output("bp_en_low", {127'd0, bus.AES_en}, 128'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    n = 0;
    while (bus.out_valid && n < 20) begin
      check_output("drain_en_low", {127'd0, bus.AES_en}, 128'd0);
      tick();
      n++;
    end
    check_output("en_low_at_drain_end", {127'd0, bus.AES_en}, 128'd0);
    tick();
    check_output("en_high_after_drain", {127'd0, bus.AES_en}, 128'd1);
    wait_quiet();

    // timeout, then clear with a pulse
    stub_mute = 1;
    push_block({4{$urandom()}});
    measure_timeout_run(n);
    check_output("timeout_en_cycles", 128'(n), 128'd16);
    check_output("timeout_err_set", {127'd0, bus.err_timeout}, 128'd1);
    check_output("timeout_no_out", {127'd0, bus.out_valid}, 128'd0);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    check_output("err_clr_pulse", {127'd0, bus.err_timeout}, 128'd0);

    // a normal block after the timeout
    stub_mute = 0;
    push_block(PT_F);
    wait_quiet();

    // clear held across a timeout edge wins over the set
    stub_mute = 1;
    push_block({4{$urandom()}});
    bus.err_clr = 1'b1;
    measure_timeout_run(n);
    check_output("clr_priority_cycles", 128'(n), 128'd16);
    check_output("clr_priority_err", {127'd0, bus.err_timeout}, 128'd0);
    bus.err_clr = 1'b0;

    // leave the flag set, then reset in the middle of a run
    push_block({4{$urandom()}});
    measure_timeout_run(n);
    check_output("err_set_again", {127'd0, bus.err_timeout}, 128'd1);
    push_block({4{$urandom()}});
    wait_en_rise();
    repeat (5) tick();
    push_word($urandom());
    push_word($urandom());
    #2;
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_aes_en", {127'd0, bus.AES_en}, 128'd0);
    check_output("mid_rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check_output("mid_rst_err", {127'd0, bus.err_timeout}, 128'd0);
    check_output("mid_rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
    check_output("mid_rst_key_in", bus.AES_key_in, 128'd0);
    in_words.delete();
    blk_q.delete();
    exp_out.delete();
    model_key = '0;
    stub_mute = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // after reset the buffer must start empty: a fresh block runs normally
    write_key_idle(KEY_F);
    push_block(PT_F);
    wait_quiet();

    // randomized traffic with random gaps, stalls and core latency
    write_key_idle({$urandom(), $urandom(), $urandom(), $urandom()});
    lat_cfg = 0;
    target  = rx_count + 40;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          push_word($urandom());
        end
      end
      begin
        int guard = 0;
        while (rx_count < target && guard < 5000) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          tick();
          guard++;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_quiet();
    check_output("random_rx_count", 128'(rx_count), 128'(target));
    check_output("random_exp_empty", 128'(exp_out.size()), 128'd0);
    check_output("random_err_clear", {127'd0, bus.err_timeout}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_word_stream_bridge.md
Name: aes_word_stream_bridge

Overview:
Word-level front/back end for AES_top. Assembles 32-bit plaintext words into the 128-bit AES_data_in and holds AES_en high for the whole encryption. Captures AES_data_out on AES_data_out_valid and streams the ciphertext back out as four 32-bit words. Input and output are buffered separately, so block N+1 can be collected while block N is encrypted or drained.

Parameters:
TIMEOUT_CYCLES, 128, max cycles AES_en is held without AES_data_out_valid before the block is aborted (>=2)

Ports:
AES_clk  in  1  clock, rising edge
AES_rst_n  in  1  asynchronous active-low reset
key_in  in  128  cipher key
key_wr  in  1  load key_in into key register when key_ready
key_ready  out  1  high when not in RUN
in_word  in  32  plaintext word, most-significant word first
in_valid  in  1  in_word valid
in_ready  out  1  input buffer can accept a word
out_word  out  32  ciphertext word, most-significant word first
out_valid  out  1  out_word valid
out_ready  in  1  sink accepts out_word
err_timeout  out  1  sticky timeout flag
err_clr  in  1  clears err_timeout
AES_en  out  1  to AES_top
AES_data_in  out  128  to AES_top
AES_key_in  out  128  to AES_top
AES_data_out  in  128  from AES_top
AES_data_out_valid  in  1  from AES_top

Behaviour:
- Reset (async, AES_rst_n=0): state IDLE; all counters 0; key, input, output and AES_data_in registers 0; AES_en=0; out_valid=0; err_timeout=0; in_ready=1; key_ready=1.
- All outputs are registered or decoded directly from state/counters; no combinational path from in_valid to in_ready.
- Input buffer: 4x32 register plus in_cnt (0..4). in_ready = (in_cnt<4).
  - Word accepted on in_valid&in_ready; it goes to slot in_cnt (slot 0 = bits 127:96); in_cnt increments.
- Key: on key_wr&key_ready the key register <= key_in. AES_key_in is driven from the key register.
- States:
  - IDLE -> RUN when in_cnt==4 and out_cnt==0. On that edge: AES_data_in <= input buffer, in_cnt <= 0, AES_en <= 1, timeout counter <= 0.
  - RUN: AES_en held 1; AES_data_in and AES_key_in stable; key_ready=0; input collection continues.
  - RUN, AES_data_out_valid sampled 1: on that edge output buffer <= AES_data_out, out_cnt <= 4, AES_en <= 0, state <= IDLE.
  - RUN, counter reaches TIMEOUT_CYCLES-1 with no valid: AES_en <= 0, err_timeout <= 1, state <= IDLE. Block discarded; output buffer untouched.
- AES_en is always low for at least one cycle between blocks, because the IDLE->RUN check requires state IDLE.
- Latency: 4th word accepted at edge T -> AES_en high after edge T+1 (if out_cnt==0). Valid sampled at edge V -> out_valid high after edge V.
- Output: out_valid = (out_cnt!=0); out_word = slot 4-out_cnt. On out_valid&out_ready, out_cnt decrements. out_word stays stable while stalled.
- A new block does not start until out_cnt==0. Input stalls only when in_cnt==4.
- AES_data_out_valid outside RUN is ignored.
- err_clr has priority over a same-cycle timeout set (flag reads 0 next cycle).
- Reset asserted mid-RUN: AES_en drops immediately (async) and all buffered data is lost.

Test Plan:
- FIPS-197 vector: key 000102030405060708090a0b0c0d0e0f; words 00112233,44556677,8899aabb,ccddeeff -> AES_en high 2 cycles after the 4th word and held until valid; out words 69c4e0d8,6a7b0430,d8cdb780,70b4c55a in order; AES_en then low.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_word stays 69c4e0d8. A second block (same 4 words) fully collected meanwhile; AES_en stays 0 until the last output word is accepted; second output matches the first.
- Input gaps: in_valid toggled 1-0-1-0 across 8 cycles -> AES_data_in=00112233_44556677_8899aabb_ccddeeff exactly at the RUN start edge; in_ready low once 4 words are held.
- Timeout: stub AES never asserts valid, TIMEOUT_CYCLES=16 -> AES_en high exactly 16 cycles; err_timeout=1; no out_valid. err_clr pulse -> err_timeout=0. Next block runs normally.
- key_wr during RUN -> key_ready=0, write ignored, AES_key_in unchanged. key_wr in IDLE -> new key visible next cycle.
- Reset mid-RUN (5 cycles after AES_en rises) -> AES_en, out_valid, in_cnt and err_timeout all 0 immediately; in_ready=1.
